// File: rtl/ahb_frame_mem.sv
// AHB slave frame memory: word-organised little-endian SRAM with byte/half/word lanes,
// programmable wait states and pipelined address/data phases. Define
// AHB_FRAME_MEM_ERR_RESP_EN to build the two-cycle ERROR response for bad accesses.
module ahb_frame_mem #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        I_MEM_HCLK,
  input  logic        I_MEM_HRESET,
  input  logic        I_MEM_HSEL,
  input  logic [31:0] I_MEM_HADDR,
  input  logic [1:0]  I_MEM_HTRANS,
  input  logic        I_MEM_HWRITE,
  input  logic [2:0]  I_MEM_HSIZE,
  input  logic [2:0]  I_MEM_HBURST,
  input  logic [31:0] I_MEM_HWDATA,
  input  logic        I_MEM_HREADY,
  output logic [31:0] O_MEM_HRDATA,
  output logic        O_MEM_HREADYOUT,
  output logic [1:0]  O_MEM_HRESP
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam bit          HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0]  WS_LAST  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef AHB_FRAME_MEM_ERR_RESP_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        be_q, be_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] offset;
  logic [31:0] rd_word;
  logic [3:0]  be_new;
  logic        addr_phase;
  logic        accept;
  logic        mem_we;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic        unused_ok;

  assign offset     = I_MEM_HADDR - BASE_ADDR;
  assign addr_phase = I_MEM_HSEL & I_MEM_HREADY & I_MEM_HTRANS[1];
  assign rd_word    = mem[idx_q];

  // Misaligned low bits and oversize HSIZE fold onto the nearest legal lane set.
  always_comb begin
    case (I_MEM_HSIZE)
      3'd0:    be_new = 4'b0001 << I_MEM_HADDR[1:0];
      3'd1:    be_new = I_MEM_HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
  end

`ifdef AHB_FRAME_MEM_ERR_RESP_EN
  logic access_err;

  always_comb begin
    access_err = 1'b0;
    if (I_MEM_HADDR < BASE_ADDR) access_err = 1'b1;
    if ((offset >> (ADDR_W + 2)) != 32'd0) access_err = 1'b1;
    if (I_MEM_HSIZE > 3'd2) access_err = 1'b1;
    if (I_MEM_HSIZE == 3'd1 && I_MEM_HADDR[0]) access_err = 1'b1;
    if (I_MEM_HSIZE == 3'd2 && I_MEM_HADDR[1:0] != 2'b00) access_err = 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    hrdata_d  = hrdata_q;
    idx_d     = idx_q;
    be_d      = be_q;
    accept    = 1'b0;
    mem_we    = 1'b0;
    hreadyout = 1'b1;
    hresp     = 2'b00;

    case (state_q)
      S_IDLE: accept = addr_phase;
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == WS_LAST) begin
          cnt_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DATA: begin
        if (write_q) mem_we = 1'b1;
        else         hrdata_d = rd_word;
        accept  = addr_phase;
        state_d = S_IDLE;
      end
`ifdef AHB_FRAME_MEM_ERR_RESP_EN
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 2'b01;
        accept  = addr_phase;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A new address phase overrides the return to idle, pipelining the next data phase.
    if (accept) begin
      idx_d   = offset[ADDR_W+1:2];
      be_d    = be_new;
      write_d = I_MEM_HWRITE;
      state_d = HAS_WAIT ? S_WAIT : S_DATA;
`ifdef AHB_FRAME_MEM_ERR_RESP_EN
      if (access_err) state_d = S_ERR1;
`endif
    end
  end

  always_ff @(posedge I_MEM_HCLK or posedge I_MEM_HRESET) begin
    if (I_MEM_HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      write_q  <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_ff @(posedge I_MEM_HCLK) begin
    idx_q <= idx_d;
    be_q  <= be_d;
  end

  // Reset drops state_q out of S_DATA at once, so an interrupted write never commits.
  always_ff @(posedge I_MEM_HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= I_MEM_HWDATA[8*b +: 8];
      end
    end
  end

  assign O_MEM_HRDATA    = (state_q == S_DATA && !write_q) ? rd_word : hrdata_q;
  assign O_MEM_HREADYOUT = hreadyout;
  assign O_MEM_HRESP     = hresp;

  assign unused_ok = ^{I_MEM_HBURST, I_MEM_HTRANS[0], offset[31:ADDR_W+2], offset[1:0]};

endmodule
